// File: rtl/wb_pkg.sv
// Shared types and defaults for the register-file writeback port arbiter.
package wb_pkg;

  localparam int AW   = 5;
  localparam int XLEN = 32;

  localparam logic [AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

  typedef enum logic [1:0] {
    SEL_IDLE = 2'd0,
    SEL_PIPE = 2'd1,
    SEL_FIFO = 2'd2
  } wb_sel_e;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Writeback sources, register-file write port and hazard query signals.
interface wb_port_arbiter_if #(
  parameter int AW   = wb_pkg::AW,
  parameter int XLEN = wb_pkg::XLEN
);

  logic            pipe_valid;
  logic [AW-1:0]   pipe_rd;
  logic [XLEN-1:0] pipe_data;
  logic            pipe_ready;

  logic            ll_valid;
  logic [AW-1:0]   ll_rd;
  logic [XLEN-1:0] ll_data;
  logic            ll_ready;

  logic            rf_we;
  logic [AW-1:0]   rf_waddr;
  logic [XLEN-1:0] rf_wdata;

  logic [AW-1:0]   qry_rs1;
  logic [AW-1:0]   qry_rs2;
  logic [AW-1:0]   qry_rd;
  logic            rs1_pend;
  logic            rs2_pend;
  logic            rd_pend;

  modport master (
    output pipe_valid, pipe_rd, pipe_data, ll_valid, ll_rd, ll_data,
           qry_rs1, qry_rs2, qry_rd,
    input  pipe_ready, ll_ready, rf_we, rf_waddr, rf_wdata,
           rs1_pend, rs2_pend, rd_pend
  );

  modport slave (
    input  pipe_valid, pipe_rd, pipe_data, ll_valid, ll_rd, ll_data,
           qry_rs1, qry_rs2, qry_rd,
    output pipe_ready, ll_ready, rf_we, rf_waddr, rf_wdata,
           rs1_pend, rs2_pend, rd_pend
  );

endinterface

// File: rtl/wb_fifo.sv
// Circular buffer for long-latency writeback results; exposes every slot's rd/valid.
module wb_fifo import wb_pkg::*; #(
  parameter int  DEPTH = 4,
  parameter int  AW    = wb_pkg::AW,
  parameter type req_t = wb_req_t
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  req_t                        wdata,
  input  logic                        pop,
  output req_t                        head,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        full,
  output logic                        empty,
  output logic [DEPTH-1:0]            ent_valid,
  output logic [DEPTH-1:0][AW-1:0]    ent_rd
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  req_t          mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  assign head  = mem[rptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // A slot is live when its distance from the read pointer is below the fill level.
  always_comb begin
    ent_valid = '0;
    ent_rd    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ent_valid[i] = ({1'b0, PW'(PW'(i) - rptr)} < count);
      ent_rd[i]    = mem[i].rd;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the WB stage and a buffered long-latency source.
module wb_port_arbiter import wb_pkg::*; #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int XLEN         = wb_pkg::XLEN,
  parameter int AW           = wb_pkg::AW
) (
  input  logic              clk,
  input  logic              rst,
  wb_port_arbiter_if.slave  bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } req_t;

  req_t                    pipe_req;
  req_t                    ll_req;
  req_t                    fifo_head;
  req_t                    sel_req;
  wb_sel_e                 sel;
  logic [CW-1:0]           count;
  logic                    full;
  logic                    empty;
  logic [DEPTH-1:0]        ent_valid;
  logic [DEPTH-1:0][AW-1:0] ent_rd;
  logic                    push;
  logic                    pop;
  logic                    force_drain;
  logic [SW-1:0]           starve_cnt;
  logic                    rf_we_q;
  logic [AW-1:0]           rf_waddr_q;
  logic [XLEN-1:0]         rf_wdata_q;
  logic                    rs1_hit;
  logic                    rs2_hit;
  logic                    rd_hit;

  assign pipe_req = '{rd: bus.pipe_rd, data: bus.pipe_data};
  assign ll_req   = '{rd: bus.ll_rd,   data: bus.ll_data};

  assign bus.ll_ready = (count < CW'(DEPTH));
  assign push         = bus.ll_valid && !full;

  assign force_drain    = (starve_cnt == SW'(STARVE_LIMIT)) && !empty;
  assign bus.pipe_ready = !force_drain;

  always_comb begin
    sel = SEL_IDLE;
    if (force_drain)         sel = SEL_FIFO;
    else if (bus.pipe_valid) sel = SEL_PIPE;
    else if (!empty)         sel = SEL_FIFO;
  end

  assign pop     = (sel == SEL_FIFO);
  assign sel_req = pop ? fifo_head : pipe_req;

  wb_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .req_t (req_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .wdata     (ll_req),
    .pop       (pop),
    .head      (fifo_head),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .ent_valid (ent_valid),
    .ent_rd    (ent_rd)
  );

  // x0 writes still complete their handshake but never assert the write enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q <= (sel != SEL_IDLE) && (sel_req.rd != AW'(REG_ZERO));
      if (sel != SEL_IDLE) begin
        rf_waddr_q <= sel_req.rd;
        rf_wdata_q <= sel_req.data;
      end
    end
  end

  assign bus.rf_we    = rf_we_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (pop || empty) begin
      starve_cnt <= '0;
    end else if ((sel == SEL_PIPE) && (starve_cnt != SW'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  always_comb begin
    rs1_hit = 1'b0;
    rs2_hit = 1'b0;
    rd_hit  = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ent_valid[i]) begin
        if (ent_rd[i] == bus.qry_rs1) rs1_hit = 1'b1;
        if (ent_rd[i] == bus.qry_rs2) rs2_hit = 1'b1;
        if (ent_rd[i] == bus.qry_rd)  rd_hit  = 1'b1;
      end
    end
  end

  assign bus.rs1_pend = rs1_hit && (bus.qry_rs1 != AW'(REG_ZERO));
  assign bus.rs2_pend = rs2_hit && (bus.qry_rs2 != AW'(REG_ZERO));
  assign bus.rd_pend  = rd_hit  && (bus.qry_rd  != AW'(REG_ZERO));

endmodule
